// File: rtl/aes_spi_slave.sv
// SPI frame responder for the AES core: collects text, key size and key from the host,
// starts the cipher datapath, then shifts the 128-bit result back out on miso.
module aes_spi_slave (
  input  logic         clk,
  input  logic         reset,
  input  logic         cs,
  input  logic         sclk,
  input  logic         mosi,
  output logic         miso,
  output logic         done,
  output logic         core_start,
  output logic [127:0] text_out,
  output logic [255:0] key_out,
  output logic [7:0]   key_size_out,
  input  logic         result_valid,
  input  logic [127:0] result,
  output logic         busy,
  output logic         frame_err
);

  typedef enum logic [2:0] {
    IDLE, RX_TEXT, RX_KSIZE, RX_KEY, WAIT_CORE, TX_RESULT, DRAIN
  } state_t;

  state_t       state, state_nxt;
  logic         cs_p0, cs_p1, cs_p2;
  logic         sclk_p0, sclk_p1, sclk_p2;
  logic         mosi_p0, mosi_p1, mosi_p2;
  logic         rise_p2, fall_p2;
  logic [2:0]   bit_cnt;
  logic [7:0]   rx_byte;
  logic [5:0]   byte_cnt, byte_cnt_nxt;
  logic [127:0] tx_sr;
  logic         cs_rise, cs_abort, byte_vld;
  logic [7:0]   byte_val;
  logic         start_nxt, err_nxt, text_we, ksize_we, key_we, tx_load;

  function automatic logic ksize_ok(input logic [7:0] v);
    return (v == 8'h10) || (v == 8'h18) || (v == 8'h20);
  endfunction

  // p0/p1: two-flop synchronizers; p2: previous synchronized value and data aligned to events
  always_ff @(posedge clk) begin
    {cs_p0, cs_p1, cs_p2}       <= {cs, cs_p0, cs_p1};
    {sclk_p0, sclk_p1, sclk_p2} <= {sclk, sclk_p0, sclk_p1};
    {mosi_p0, mosi_p1, mosi_p2} <= {mosi, mosi_p0, mosi_p1};
  end

  // p2: registered sclk edge events, qualified by chip select
  always_ff @(posedge clk) begin
    if (reset) begin
      rise_p2 <= 1'b0;
      fall_p2 <= 1'b0;
    end else begin
      rise_p2 <= sclk_p1 & ~sclk_p2 & ~cs_p1;
      fall_p2 <= ~sclk_p1 & sclk_p2 & ~cs_p1;
    end
  end

  assign cs_rise  = cs_p1 & ~cs_p2;
  assign cs_abort = cs_rise && (bit_cnt != 3'd0);
  assign byte_val = {rx_byte[6:0], mosi_p2};
  assign byte_vld = rise_p2 && (bit_cnt == 3'd7) && !cs_abort;

  always_ff @(posedge clk) begin
    if (rise_p2) rx_byte <= byte_val;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      byte_cnt   <= 6'd0;
      bit_cnt    <= 3'd0;
      done       <= 1'b0;
      core_start <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_nxt;
      byte_cnt   <= byte_cnt_nxt;
      done       <= byte_vld;
      core_start <= start_nxt;
      frame_err  <= err_nxt;
      if (cs_abort)     bit_cnt <= 3'd0;
      else if (rise_p2) bit_cnt <= bit_cnt + 3'd1;
    end
  end

  always_comb begin
    state_nxt    = state;
    byte_cnt_nxt = byte_cnt;
    start_nxt    = 1'b0;
    err_nxt      = 1'b0;
    text_we      = 1'b0;
    ksize_we     = 1'b0;
    key_we       = 1'b0;
    tx_load      = 1'b0;
    if (cs_abort) begin
      err_nxt      = 1'b1;
      state_nxt    = IDLE;
      byte_cnt_nxt = 6'd0;
    end else begin
      case (state)
        IDLE: if (byte_vld) begin
          text_we      = 1'b1;
          byte_cnt_nxt = 6'd1;
          state_nxt    = RX_TEXT;
        end
        RX_TEXT: if (byte_vld) begin
          text_we = 1'b1;
          if (byte_cnt == 6'd15) begin
            byte_cnt_nxt = 6'd0;
            state_nxt    = RX_KSIZE;
          end else begin
            byte_cnt_nxt = byte_cnt + 6'd1;
          end
        end
        RX_KSIZE: if (byte_vld) begin
          if (ksize_ok(byte_val)) begin
            ksize_we     = 1'b1;
            byte_cnt_nxt = byte_val[5:0] - 6'd1;
            state_nxt    = RX_KEY;
          end else begin
            err_nxt   = 1'b1;
            state_nxt = DRAIN;
          end
        end
        RX_KEY: if (byte_vld) begin
          key_we = 1'b1;
          if (byte_cnt == 6'd0) begin
            start_nxt = 1'b1;
            state_nxt = WAIT_CORE;
          end else begin
            byte_cnt_nxt = byte_cnt - 6'd1;
          end
        end
        // host bytes arriving here are clocked but discarded
        WAIT_CORE: if (result_valid) begin
          tx_load      = 1'b1;
          byte_cnt_nxt = 6'd0;
          state_nxt    = TX_RESULT;
        end
        TX_RESULT: if (byte_vld) begin
          if (byte_cnt == 6'd15) begin
            byte_cnt_nxt = 6'd0;
            state_nxt    = IDLE;
          end else begin
            byte_cnt_nxt = byte_cnt + 6'd1;
          end
        end
        DRAIN: if (cs_rise) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      text_out     <= '0;
      key_out      <= '0;
      key_size_out <= '0;
    end else begin
      if (text_we) text_out <= {text_out[119:0], byte_val};
      if (ksize_we) begin
        key_size_out <= byte_val;
        key_out      <= '0;
      end
      if (key_we) key_out[{byte_cnt[4:0], 3'b000} +: 8] <= byte_val;
    end
  end

  always_ff @(posedge clk) begin
    if (tx_load)                              tx_sr <= result;
    else if (fall_p2 && state == TX_RESULT)   tx_sr <= {tx_sr[126:0], 1'b0};
  end

  assign miso = (state == TX_RESULT) & tx_sr[127];
  assign busy = (state != IDLE);

endmodule

// File: tb/tb_aes_spi_slave.sv
// Bench for aes_spi_slave: host-side SPI driver, byte-level frame model, single compare process.
module tb_aes_spi_slave;
  localparam int H = 5;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         cs = 1'b1;
  logic         sclk = 1'b0;
  logic         mosi = 1'b0;
  logic         result_valid = 1'b0;
  logic [127:0] result = '0;
  logic         miso, done, core_start, busy, frame_err;
  logic [127:0] text_out;
  logic [255:0] key_out;
  logic [7:0]   key_size_out;

  aes_spi_slave dut (
    .clk(clk), .reset(reset), .cs(cs), .sclk(sclk), .mosi(mosi), .miso(miso),
    .done(done), .core_start(core_start), .text_out(text_out), .key_out(key_out),
    .key_size_out(key_size_out), .result_valid(result_valid), .result(result),
    .busy(busy), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  // expectations, written by the stimulus only
  logic [127:0] exp_text = '0;
  logic [255:0] exp_key = '0;
  int           exp_ks = 0;
  int           frame_base = 0;
  bit           quiet = 1'b0;
  logic [7:0]   kb [32];
  int           req_seq = 0;
  int           req_kind = 0;
  string        req_name = "";
  logic [255:0] req_act = '0;
  logic [255:0] req_exp = '0;

  // observations and tallies, written by the compare process only
  int done_cnt = 0, cs_cnt = 0, fe_cnt = 0, seen_seq = 0;
  int n_chk = 0, n_pass = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h required %0h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (frame_err) fe_cnt++;
    if (core_start) begin
      cs_cnt++;
      chk("start_text", 256'(text_out), 256'(exp_text));
      chk("start_key", key_out, exp_key);
      chk("start_ksize", 256'(key_size_out), 256'(exp_ks));
      chk("start_byte_pos", 256'(done_cnt - frame_base), 256'(17 + exp_ks));
    end
    if (quiet) chk("miso_quiet", 256'(miso), '0);
    if (req_seq != seen_seq) begin
      seen_seq = req_seq;
      case (req_kind)
        0: begin
          chk({req_name, "_miso"}, 256'(miso), '0);
          chk({req_name, "_done"}, 256'(done), '0);
          chk({req_name, "_core_start"}, 256'(core_start), '0);
          chk({req_name, "_frame_err"}, 256'(frame_err), '0);
          chk({req_name, "_busy"}, 256'(busy), '0);
          chk({req_name, "_text"}, 256'(text_out), '0);
          chk({req_name, "_key"}, key_out, '0);
          chk({req_name, "_ksize"}, 256'(key_size_out), '0);
        end
        1: chk(req_name, req_act, req_exp);
        2: chk(req_name, 256'(busy), req_exp);
        3: chk(req_name, 256'(done_cnt), req_exp);
        4: chk(req_name, 256'(cs_cnt), req_exp);
        5: chk(req_name, 256'(fe_cnt), req_exp);
        6: chk(req_name, 256'(text_out), req_exp);
        7: chk(req_name, key_out, req_exp);
        default: chk(req_name, 256'(key_size_out), req_exp);
      endcase
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic post(input int kind, input string name, input logic [255:0] act,
                      input logic [255:0] exp);
    req_kind = kind;
    req_name = name;
    req_act  = act;
    req_exp  = exp;
    req_seq++;
    @(negedge clk);
    #1;
  endtask

  // host side of one SPI mode-0 byte (or its first nbits bits)
  task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = '0;
    for (int i = 7; i > 7 - nbits; i--) begin
      mosi = tx[i];
      tick(H);
      sclk = 1'b1;
      rx = {rx[6:0], miso};
      tick(H);
      sclk = 1'b0;
    end
    tick(H);
  endtask

  // full frame; rst_at < 16 applies reset before that response byte
  task automatic run_txn(input logic [127:0] text, input int ks, input logic [127:0] res,
                         input int dummies, input int rst_at);
    logic [7:0] r;
    int base, c0;
    exp_text = text;
    exp_ks   = ks;
    exp_key  = '0;
    for (int i = 0; i < ks; i++) exp_key[8*(ks-1-i) +: 8] = kb[i];
    base = done_cnt;
    c0 = cs_cnt;
    frame_base = base;
    cs = 1'b0;
    tick(H);
    for (int i = 0; i < 16; i++) begin
      spi_bits(text[127-8*i -: 8], 8, r);
      if ($urandom_range(0, 3) == 0) begin
        cs = 1'b1;
        tick(H);
        cs = 1'b0;
        tick(H);
      end
    end
    spi_bits(8'(ks), 8, r);
    for (int i = 0; i < ks; i++) spi_bits(kb[i], 8, r);
    post(3, "done_count_rx", '0, 256'(base + 17 + ks));
    post(4, "core_start_count", '0, 256'(c0 + 1));
    post(2, "busy_wait_core", '0, 256'(1));
    for (int d = 0; d < dummies; d++) begin
      spi_bits(8'($urandom), 8, r);
      post(1, "wait_core_miso_byte", 256'(r), '0);
    end
    quiet = 1'b0;
    result = res;
    result_valid = 1'b1;
    tick(1);
    result_valid = 1'b0;
    tick(2);
    for (int i = 0; i < 16; i++) begin
      if (i == rst_at) begin
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        post(0, "reset_in_tx", '0, '0);
        break;
      end
      spi_bits(8'($urandom), 8, r);
      post(1, "resp_byte", 256'(r), 256'(res[127-8*i -: 8]));
    end
    quiet = 1'b1;
    if (rst_at >= 16) begin
      post(2, "busy_after_tx", '0, '0);
      post(3, "done_count_total", '0, 256'(base + 33 + ks + dummies));
    end
    cs = 1'b1;
    tick(2 * H);
  endtask

  task automatic rand_frame(input int rst_at);
    logic [127:0] t, res;
    int ks;
    t   = {$urandom, $urandom, $urandom, $urandom};
    res = {$urandom, $urandom, $urandom, $urandom};
    ks  = 16 + 8 * $urandom_range(0, 2);
    for (int i = 0; i < 32; i++) kb[i] = 8'($urandom);
    run_txn(t, ks, res, $urandom_range(0, 2), rst_at);
  endtask

  initial begin
    logic [7:0] r;
    logic [7:0] bad;
    int f0, c0;
    tick(3);
    reset = 1'b0;
    post(0, "reset_state", '0, '0);
    quiet = 1'b1;

    // result strobe while idle must not start anything
    result = {$urandom, $urandom, $urandom, $urandom};
    result_valid = 1'b1;
    tick(1);
    result_valid = 1'b0;
    tick(2);
    post(2, "busy_rv_idle", '0, '0);

    for (int i = 0; i < 32; i++) kb[i] = 8'(i);
    run_txn(128'h00112233445566778899aabbccddeeff, 32,
            128'h8ea2b7ca516745bfeafc49904b496089, 1, 16);
    post(6, "lit_text", '0, 256'(128'h00112233445566778899aabbccddeeff));
    post(7, "lit_key256", '0,
         256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f);
    post(8, "lit_ksize32", '0, 256'(8'h20));

    run_txn(128'hffeeddccbbaa99887766554433221100, 16,
            128'h0123456789abcdeffedcba9876543210, 0, 16);
    post(7, "lit_key128", '0, 256'(128'h000102030405060708090a0b0c0d0e0f));

    for (int n = 0; n < 3; n++) rand_frame(16);

    // unsupported key size
    f0 = fe_cnt;
    c0 = cs_cnt;
    do bad = 8'($urandom); while (bad == 8'h10 || bad == 8'h18 || bad == 8'h20);
    cs = 1'b0;
    tick(H);
    for (int i = 0; i < 16; i++) spi_bits(8'($urandom), 8, r);
    spi_bits(bad, 8, r);
    post(5, "frame_err_badsize", '0, 256'(f0 + 1));
    for (int i = 0; i < 3; i++) begin
      spi_bits(8'($urandom), 8, r);
      post(1, "drain_miso_byte", 256'(r), '0);
    end
    post(2, "busy_drain", '0, 256'(1));
    cs = 1'b1;
    tick(2 * H);
    post(2, "busy_after_drain", '0, '0);
    post(4, "no_core_start_bad", '0, 256'(c0));

    // partial byte abort inside text byte 3
    f0 = fe_cnt;
    cs = 1'b0;
    tick(H);
    for (int i = 0; i < 3; i++) spi_bits(8'($urandom), 8, r);
    spi_bits(8'($urandom), 5, r);
    cs = 1'b1;
    tick(2 * H);
    post(5, "frame_err_partial", '0, 256'(f0 + 1));
    post(2, "busy_after_abort", '0, '0);
    rand_frame(16);

    // reset after 7 response bytes, then a clean frame
    rand_frame(7);
    rand_frame(16);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
